// File: rtl/l2_mem_ctrl.sv
// l2_mem_ctrl: services the granted L2 request stream against an internal
// word-addressed backing store with fixed, parameterized read/write latency.
// One request is in flight at a time; completion is a one-cycle pulse.
module l2_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 3,
  parameter int WR_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] l2_mem_access_addr,
  input  logic [31:0] l2_mem_wr_data,
  input  logic        l2_mem_wr_en,
  input  logic        l2_mem_en,
  output logic [31:0] l2_mem_rd_data,
  output logic        l2_mem_rd_valid,
  output logic        l2_mem_wr_done,
  output logic        l2_mem_busy,
  output logic        l2_mem_addr_err
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int IDX_W   = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [29:0]       word_p0;
  logic [31:0]       wr_data_p0;
  logic [31:0]       mem [DEPTH_WORDS];
  logic              accept;
  logic              done;
  logic              in_range;
  logic              rd_done;
  logic              wr_fire;

  // Byte-lane bits of the address carry no meaning for a word store.
  logic unused_addr_bits;
  assign unused_addr_bits = ^l2_mem_access_addr[1:0];

  assign accept   = (state == IDLE) && l2_mem_en;
  assign done     = (state != IDLE) && (cnt == '0);
  assign in_range = ({1'b0, word_p0} < 31'(DEPTH_WORDS));
  assign rd_done  = done && (state == RD_WAIT);
  assign wr_fire  = done && (state == WR_WAIT);
  assign l2_mem_busy = (state != IDLE);

  // State register; reset discards any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept only in IDLE, return to IDLE when the wait count expires.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:             if (l2_mem_en) state_nxt = l2_mem_wr_en ? WR_WAIT : RD_WAIT;
      RD_WAIT, WR_WAIT: if (cnt == '0) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // Latency down-counter, loaded with LAT-1 so LAT wait edges elapse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= l2_mem_wr_en ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
    end else if (state != IDLE) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Request capture stage: inputs are sampled only at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_p0    <= l2_mem_access_addr[31:2];
      wr_data_p0 <= l2_mem_wr_data;
    end
  end

  // Response stage: registered pulses and read data; reset wins over completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      l2_mem_rd_valid <= 1'b0;
      l2_mem_wr_done  <= 1'b0;
      l2_mem_addr_err <= 1'b0;
      l2_mem_rd_data  <= '0;
    end else begin
      l2_mem_rd_valid <= rd_done;
      l2_mem_wr_done  <= wr_fire;
      l2_mem_addr_err <= done && !in_range;
      if (rd_done) begin
        l2_mem_rd_data <= in_range ? mem[word_p0[IDX_W-1:0]] : '0;
      end
    end
  end

  // Backing store update; suppressed by reset and for out-of-range words.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire && in_range) begin
      mem[word_p0[IDX_W-1:0]] <= wr_data_p0;
    end
  end

endmodule

// File: doc/l2_mem_ctrl.md
Name: l2_mem_ctrl

Overview:
- Downstream stage of the L2 bus arbiter. It consumes the single granted L2 request stream (address, write data, write enable, enable) and services it against an internal word-addressed L2 backing store.
- Read and write latencies are fixed and parameterized. Completion is signalled by one-cycle response pulses, and a busy flag lets upstream logic hold off new requests.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the backing store (power of two, at least 2).
- RD_LAT, 3: cycles from read acceptance edge to the rd_valid cycle (at least 1).
- WR_LAT, 2: cycles from write acceptance edge to the memory update edge (at least 1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- l2_mem_access_addr  in  32  byte address; bits [1:0] ignored, word index = addr[31:2].
- l2_mem_wr_data  in  32  write data.
- l2_mem_wr_en  in  1  1 = write, 0 = read; qualified by l2_mem_en.
- l2_mem_en  in  1  request valid.
- l2_mem_rd_data  out  32  read data; valid when rd_valid = 1, holds until the next read completes.
- l2_mem_rd_valid  out  1  one-cycle read completion pulse.
- l2_mem_wr_done  out  1  one-cycle write completion pulse.
- l2_mem_busy  out  1  high while a request is in flight.
- l2_mem_addr_err  out  1  one-cycle pulse, coincident with rd_valid or wr_done, for an out-of-range access.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state = IDLE; all outputs 0 (rd_data = 0). Any in-flight request is discarded with no response pulse and no memory update. Memory contents are not reset.
- States: IDLE, RD_WAIT, WR_WAIT. busy = (state != IDLE), decoded from registered state.
- Acceptance:
  - In IDLE with en = 1 at edge E0: latch addr, wr_data and wr_en.
  - Load the down-counter with RD_LAT-1 or WR_LAT-1, according to the latched wr_en.
  - Go to RD_WAIT or WR_WAIT.
- Requests while busy: en = 1 outside IDLE is ignored. It is not queued, and inputs are not re-sampled.
- RD_WAIT / WR_WAIT: the counter decrements each edge. At the edge where counter == 0:
  - Read: rd_data <= mem[idx], or 0 if out of range; rd_valid <= 1.
  - Write: mem[idx] <= latched data if in range; wr_done <= 1.
  - In both cases, state <= IDLE.
- Read timing: rd_valid is high in the cycle following edge E_RD_LAT (E0 = acceptance edge). Write timing: the memory is updated at edge E_WR_LAT and wr_done is high in the following cycle.
- Response cycle: the response pulse coincides with busy = 0. A request presented in that cycle is accepted, so peak throughput is one read per RD_LAT+1 cycles and one write per WR_LAT+1 cycles.
- Held enable: if en stays high after a response, it is treated as a new request. The requester must drop en or change the request on seeing the pulse.
- Out of range (word index >= DEPTH_WORDS):
  - Full latency still applies.
  - addr_err pulses together with the response.
  - Reads return 0; writes are dropped.
- Counter width: clog2(max(RD_LAT, WR_LAT)). Latency 1 means the counter is loaded with 0 and the response follows after exactly one wait edge.
- Reset during RD_WAIT or WR_WAIT: the next cycle is IDLE, busy = 0, no pulse, and memory is unchanged even if the reset edge coincides with the update edge. Reset has priority.
- Pulse outputs (rd_valid, wr_done, addr_err) are 0 in every cycle other than the response cycle.

Test Plan:
- Reset: assert rst for 2 cycles with en = 1 held -> busy, rd_valid, wr_done, addr_err and rd_data all 0; no acceptance while rst = 1.
- Write then read (RD_LAT = 3, WR_LAT = 2):
  - Write addr 0x0000_0010, data 0xDEADBEEF, en pulsed 1 cycle -> busy for 2 cycles, then wr_done for 1 cycle.
  - Read addr 0x0000_0013 -> rd_valid 3 cycles after acceptance with rd_data = 0xDEADBEEF; addr_err = 0.
- Request while busy: accept a read of 0x10, then during RD_WAIT present a write to 0x10 with 0x12345678 -> ignored.
  - rd_valid returns 0xDEADBEEF.
  - A later read of 0x10 still returns 0xDEADBEEF.
- Out of range:
  - Write addr 0x0000_1000 (word 1024) -> wr_done with addr_err = 1 after 2 cycles.
  - Read 0x0000_1000 -> rd_valid with addr_err = 1 and rd_data = 0.
  - Word 0 is unchanged.
- Reset mid-read: accept a read, assert rst in the 2nd wait cycle -> no rd_valid ever; busy = 0 in the cycle after the reset edge; rd_data = 0.
- Back-to-back: hold a read with en = 1 continuously to addr 0x10 -> rd_valid pulses every 4 cycles (RD_LAT+1), each with 0xDEADBEEF.
